urand_pair_gen: RTL

//  Uniform source directly upstream of randist. Two xorshift64 generators yield a pair
//  of IEEE-754 doubles U1,U2 strictly inside (0,1) per push. Bursts of N pairs.

---
 rtl/urand_pair_gen_pkg.sv | 48 ++++
 rtl/urand_pair_gen_if.sv | 28 ++
 rtl/u53_to_double.sv | 56 +++++
 rtl/urand_pair_gen.sv | 119 +++++++++++
 4 files changed

// File: rtl/urand_pair_gen_pkg.sv
`default_nettype none
// ============================================================================
// urand_pair_gen_pkg
// Shared constants, FSM encoding and helpers for the uniform pair generator.
// Revision: 1.0
// ============================================================================
package urand_pair_gen_pkg;

    localparam logic [63:0] GOLD         = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [63:0] SEED_ZSUB    = 64'h0000_0000_0000_0001;
    localparam logic [63:0] SEED_RST_DEF = 64'h0123_4567_89AB_CDEF;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int BIAS   = 1023;
    localparam int MANT_W = FRAC_W + 1;
    localparam int LZC_W  = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    // xorshift has an all-zero fixed point, so a zero seed is never stored
    function automatic logic [63:0] seed_fix(input logic [63:0] s);
        return (s == 64'd0) ? SEED_ZSUB : s;
    endfunction

    // Ascending scan lets the highest set bit win; m is always odd, never 0
    function automatic logic [LZC_W-1:0] lzc53(input logic [MANT_W-1:0] m);
        logic [LZC_W-1:0] n;
        n = LZC_W'(MANT_W - 1);
        for (int i = 0; i < MANT_W; i++) begin
            if (m[i]) n = LZC_W'(MANT_W - 1 - i);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/urand_pair_gen_if.sv
`default_nettype none
// ============================================================================
// urand_pair_gen_if
// Control and uniform-pair output bundle between the generator and its user.
// Revision: 1.0
// ============================================================================
interface urand_pair_gen_if;
    logic        seed_load;
    logic [63:0] seed;
    logic        start;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        pushout;
    logic [63:0] U1;
    logic [63:0] U2;

    modport master (
        output seed_load, seed, start, count,
        input  busy, done, pushout, U1, U2
    );

    modport slave (
        input  seed_load, seed, start, count,
        output busy, done, pushout, U1, U2
    );
endinterface
`default_nettype wire

// File: rtl/u53_to_double.sv
`default_nettype none
// ============================================================================
// u53_to_double
// Exact conversion of a 53-bit odd integer m to the double m*2^-53 (2 stages).
// Revision: 1.0
// ============================================================================
module u53_to_double
    import urand_pair_gen_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic [MANT_W-1:0] m,
    output logic                   s1_valid,
    output logic                   out_valid,
    output logic [63:0]            u
);

    logic              r_s1_v;
    logic [FRAC_W-1:0] r_s1_frac;
    logic [LZC_W-1:0]  r_s1_lzc;
    logic              r_s2_v;
    logic [63:0]       r_u;
    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;

    // The implicit leading one is shifted out, so only the low 52 bits matter
    assign w_exp  = EXP_W'(BIAS - 1) - EXP_W'(r_s1_lzc);
    assign w_frac = r_s1_frac << r_s1_lzc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_frac <= '0;
            r_s1_lzc  <= '0;
            r_s2_v    <= 1'b0;
            r_u       <= '0;
        end else begin
            r_s1_v <= in_valid;
            r_s2_v <= r_s1_v;
            if (in_valid) begin
                r_s1_frac <= m[FRAC_W-1:0];
                r_s1_lzc  <= lzc53(m);
            end
            if (r_s1_v) begin
                r_u <= {1'b0, w_exp, w_frac};
            end
        end
    end

    assign s1_valid  = r_s1_v;
    assign out_valid = r_s2_v;
    assign u         = r_u;

endmodule
`default_nettype wire

// File: rtl/urand_pair_gen.sv
`default_nettype none
// ============================================================================
// urand_pair_gen
// Dual xorshift64 source emitting bursts of uniform double pairs in (0,1).
// Revision: 1.0
// ============================================================================
module urand_pair_gen
    import urand_pair_gen_pkg::*;
#(
    parameter logic [63:0] SEED_RST = SEED_RST_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    urand_pair_gen_if.slave  bus
);

    fsm_e        r_state;
    logic [15:0] r_remaining;
    logic [63:0] r_g1;
    logic [63:0] r_g2;
    logic        r_v0;
    logic        r_l0;
    logic        r_l1;
    logic        r_l2;
    logic        r_zdone;

    logic        w_busy;
    logic        w_accept;
    logic        w_load;
    logic        w_draw;
    logic        w_last;
    logic        w_count_nz;
    logic [63:0] w_g1_base;
    logic [63:0] w_g2_base;
    logic        w_s1_a, w_s1_b;
    logic        w_p_a, w_p_b;
    logic        w_s1;
    logic        w_push;

    assign w_s1       = w_s1_a | w_s1_b;
    assign w_push     = w_p_a & w_p_b;
    assign w_busy     = (r_state == RUN) | r_v0 | w_s1 | w_push;
    assign w_count_nz = (bus.count != 16'd0);
    assign w_accept   = !w_busy && bus.start;
    assign w_load     = !w_busy && bus.seed_load;

    assign w_draw = (w_accept && w_count_nz) ||
                    (r_state == RUN && r_remaining != 16'd0);
    assign w_last = (w_accept && bus.count == 16'd1) ||
                    (r_state == RUN && r_remaining == 16'd1);

    // A seed loaded together with start feeds straight into draw #1
    assign w_g1_base = w_load ? seed_fix(bus.seed)        : r_g1;
    assign w_g2_base = w_load ? seed_fix(bus.seed ^ GOLD) : r_g2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= 16'd0;
            r_g1        <= SEED_RST;
            r_g2        <= SEED_RST ^ GOLD;
            r_v0        <= 1'b0;
            r_l0        <= 1'b0;
            r_l1        <= 1'b0;
            r_l2        <= 1'b0;
            r_zdone     <= 1'b0;
        end else begin
            r_g1    <= w_draw ? xorshift64(w_g1_base) : w_g1_base;
            r_g2    <= w_draw ? xorshift64(w_g2_base) : w_g2_base;
            r_v0    <= w_draw;
            r_l0    <= w_last;
            r_l1    <= r_l0;
            r_l2    <= r_l1;
            r_zdone <= w_accept && !w_count_nz;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_count_nz) begin
                        r_state     <= RUN;
                        r_remaining <= bus.count - 16'd1;
                    end
                end
                RUN: begin
                    if (r_remaining == 16'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_remaining <= r_remaining - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    u53_to_double u_conv1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_v0),
        .m         ({r_g1[63:12], 1'b1}),
        .s1_valid  (w_s1_a),
        .out_valid (w_p_a),
        .u         (bus.U1)
    );

    u53_to_double u_conv2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_v0),
        .m         ({r_g2[63:12], 1'b1}),
        .s1_valid  (w_s1_b),
        .out_valid (w_p_b),
        .u         (bus.U2)
    );

    assign bus.busy    = w_busy;
    assign bus.pushout = w_push;
    assign bus.done    = r_zdone | (w_push & r_l2);

endmodule
`default_nettype wire
